spram_arbiter: RTL
==================

# spram_arbiter

Two-port arbiter that shares one single-port `spram` instance between a high-priority requester (port A, e.g. Z80 work-RAM bus) and a low-priority requester (port B, e.g. cartridge-RAM save/restore or bulk loader). It grants at most one access per cycle, returns read data with one-cycle latency, and holds each port's last read data until that port's next read. Port B is protected from starvation by a bounded wait counter.

## Interface
- `ADDR_W`, 15: address width, passed to `spram.widthad_a`.
- `DATA_W`, 8: data width, passed to `spram.width_a`.
- `STARVE_LIMIT`, 7: consecutive losing cycles after which B is force-granted. Must be ≥1.

Ports:
- `clock`  in  1  single clock; every register is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  A access request; level, held until `a_ack`.
- `a_we`  in  1  A write (1) / read (0); stable while `a_req` is high.
- `a_addr`  in  ADDR_W  A address; stable while `a_req` is high.
- `a_wdata`  in  DATA_W  A write data; stable while `a_req` is high.
- `a_ack`  out  1  A access issued to RAM this cycle; combinational.
- `a_rvalid`  out  1  A read data valid; one-cycle pulse.
- `a_rdata`  out  DATA_W  A read data.
- `b_*`  identical set for port B.

## Operation
- Grant decision (combinational, per cycle):
  - Only one port requesting: that port is granted.
  - Both requesting, default mode: A is granted unless `starve_cnt == STARVE_LIMIT`, in which case B is granted.
  - Neither requesting: no grant, `ram_wren = 0`, RAM address is don't-care. No read is issued, so `q` is unchanged.
- The granted port's `addr`, `wdata` and `we` drive the `spram` instance. `x_ack = x_req & granted_x`.
- `starve_cnt` has width `$clog2(STARVE_LIMIT+1)`:
  - Increments when `b_req & !b_ack`.
  - Clears when `b_ack` or `!b_req`.
  - Saturates at `STARVE_LIMIT`.
- Read return:
  - `rd_pending_x` is set at the end of the ack'd read cycle and lasts one cycle.
  - `x_rvalid = rd_pending_x`.
  - `x_rdata = rd_pending_x ? ram_q : hold_x`.
  - `hold_x` captures `ram_q` on the cycle `x_rvalid` is high.
- Writes produce no `rvalid`. A write does not alter either port's `rdata`.
- A requester may drop `req` only after `ack`. Dropping it earlier is a protocol violation, and the result is undefined for verification.
- Reset values:
  - `rd_pending_a/b = 0`, so `a_rvalid = b_rvalid = 0`.
  - `hold_a = hold_b = 0`, so `a_rdata = b_rdata = 0`.
  - `starve_cnt = 0`; RR pointer = A.
  - RAM contents are not cleared.
- Reset asserted mid-operation: any in-flight read's `rvalid` is suppressed immediately, and the write issued in the reset cycle is blocked (`ram_wren` forced 0 while `reset_n = 0`).

## Timing
- Throughput: one access per cycle, back-to-back across ports or within a port.
- Read latency: ack in cycle T gives `rvalid` and valid `rdata` in T+1. The data is held stable from T+2 until the next `rvalid` on that port.
- Write: RAM is updated at the rising edge ending ack cycle T. A read of the same address ack'd in T+1 returns the new data in T+2.
- Worst-case B wait in default mode: `STARVE_LIMIT` losing cycles, then granted in the next cycle. A is stalled for that one cycle.
- Simultaneous A read then B read in consecutive cycles: `a_rvalid` in T+1 and `b_rvalid` in T+2. Each port's `rdata` stays independent.

## Configuration
- `SPRAM_ARB_RR_EN`:
  - Defined: round-robin. On contention, the port not granted last gets the grant. The pointer updates on every ack. `starve_cnt` logic is not built, and `STARVE_LIMIT` is ignored.
  - Undefined: fixed A priority with the starvation counter, as described under Operation.

## Structure
- Shared package `sms_mem_pkg` holds:
  - the `gnt_e` enum: `GNT_NONE`, `GNT_A`, `GNT_B`;
  - default `ADDR_W` and `DATA_W` constants.
- One sub-module: the existing `spram`, instanced as `u_ram`. Arbitration, the starvation counter and the return path stay in `spram_arbiter`.

## Test plan
- Reset, then A writes 0x5A to 0x0010, then A reads 0x0010 → `a_ack` in each request cycle. `a_rvalid` is high one cycle later with `a_rdata = 0x5A`, and `a_rdata` is still 0x5A three cycles later.
- A and B both read continuously, default mode, `STARVE_LIMIT = 7` → the grant sequence is A×7, B×1, repeating. B never waits more than 8 cycles.
- With `SPRAM_ARB_RR_EN`, A and B both read continuously → the grant sequence alternates A, B, A, B.
- B writes 0x33 to 0x7FFF (top address), then A reads 0x7FFF in the next cycle → `a_rdata = 0x33`, and B's `rdata` is unchanged.
- A read is ack'd, then `reset_n` is pulled low before the next edge → no `a_rvalid` is seen. After reset, `a_rdata = 0` and a subsequent read returns the stored RAM data (contents preserved).
- Idle cycles between accesses → no ack and no `rvalid`. Previously held `rdata` is unchanged on both ports.

Source files
------------

// File: rtl/sms_mem_pkg.sv
// Shared memory-subsystem types: grant encoding and default RAM geometry.
package sms_mem_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/spram.sv
// Single-port synchronous RAM: write-on-wren, registered read-on-rden.
// q is left unchanged on cycles with no read issued.
module spram #(
    parameter int widthad_a = 15,
    parameter int width_a   = 8
) (
    input  logic                 clock,
    input  logic [widthad_a-1:0] address,
    input  logic [width_a-1:0]   data,
    input  logic                 wren,
    input  logic                 rden,
    output logic [width_a-1:0]   q
);

    logic [width_a-1:0] mem_r [0:(2**widthad_a)-1];

    // Array write port and registered read port; contents are never cleared.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem_r[address] <= data;
        end
        if (rden) begin
            q <= mem_r[address];
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-port arbiter sharing one spram between high-priority port A and port B.
// Build option SPRAM_ARB_RR_EN selects round-robin instead of A-priority with starvation guard.
module spram_arbiter
    import sms_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata
);

    gnt_e              gnt_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              ram_we_s;
    logic              ram_wren_s;
    logic              ram_rden_s;
    logic [DATA_W-1:0] ram_q_s;
    logic              rd_pending_a_r;
    logic              rd_pending_b_r;
    logic [DATA_W-1:0] hold_a_r;
    logic [DATA_W-1:0] hold_b_r;

`ifdef SPRAM_ARB_RR_EN
    logic rr_pref_b_r;

    // Contention preference flips to the other port after every ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_pref_b_r <= 1'b0;
        end else if (a_ack) begin
            rr_pref_b_r <= 1'b1;
        end else if (b_ack) begin
            rr_pref_b_r <= 1'b0;
        end else begin
            rr_pref_b_r <= rr_pref_b_r;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;

    // Count consecutive cycles B waits; saturate so the force-grant condition holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (b_req && !b_ack) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end
`endif

    // Per-cycle grant decision.
    always_comb begin
        gnt_s = GNT_NONE;
        if (a_req && b_req) begin
`ifdef SPRAM_ARB_RR_EN
            gnt_s = rr_pref_b_r ? GNT_B : GNT_A;
`else
            gnt_s = (starve_cnt_r == STARVE_MAX) ? GNT_B : GNT_A;
`endif
        end else if (a_req) begin
            gnt_s = GNT_A;
        end else if (b_req) begin
            gnt_s = GNT_B;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Steer the granted port onto the RAM.
    always_comb begin
        ram_addr_s  = {ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        ram_we_s    = 1'b0;
        case (gnt_s)
            GNT_A: begin
                ram_addr_s  = a_addr;
                ram_wdata_s = a_wdata;
                ram_we_s    = a_we;
            end
            GNT_B: begin
                ram_addr_s  = b_addr;
                ram_wdata_s = b_wdata;
                ram_we_s    = b_we;
            end
            default: begin
                ram_addr_s  = {ADDR_W{1'b0}};
                ram_wdata_s = {DATA_W{1'b0}};
                ram_we_s    = 1'b0;
            end
        endcase
    end

    assign a_ack = a_req & (gnt_s == GNT_A);
    assign b_ack = b_req & (gnt_s == GNT_B);

    // Nothing reaches the array while reset is asserted, even if a port is granted.
    assign ram_wren_s = ram_we_s & reset_n;
    assign ram_rden_s = (gnt_s != GNT_NONE) & ~ram_we_s & reset_n;

    spram #(
        .widthad_a (ADDR_W),
        .width_a   (DATA_W)
    ) u_ram (
        .clock   (clock),
        .address (ram_addr_s),
        .data    (ram_wdata_s),
        .wren    (ram_wren_s),
        .rden    (ram_rden_s),
        .q       (ram_q_s)
    );

    // Read return: one-cycle valid pulse, then the port keeps its last data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_a_r <= 1'b0;
            rd_pending_b_r <= 1'b0;
            hold_a_r       <= {DATA_W{1'b0}};
            hold_b_r       <= {DATA_W{1'b0}};
        end else begin
            rd_pending_a_r <= a_ack & ~a_we;
            rd_pending_b_r <= b_ack & ~b_we;
            hold_a_r       <= rd_pending_a_r ? ram_q_s : hold_a_r;
            hold_b_r       <= rd_pending_b_r ? ram_q_s : hold_b_r;
        end
    end

    assign a_rvalid = rd_pending_a_r;
    assign b_rvalid = rd_pending_b_r;
    assign a_rdata  = rd_pending_a_r ? ram_q_s : hold_a_r;
    assign b_rdata  = rd_pending_b_r ? ram_q_s : hold_b_r;

endmodule
